// File: rtl/square_move_scheduler_if.sv
// Button/switch/frame inputs and position outputs of the square motion
// controller, bundled so the scheduler and its driver share one definition.
interface square_move_scheduler_if;
  logic [3:0] push;
  logic       switch;
  logic       frame_tick;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       move_pulse;
  logic [3:0] btn_db;

  modport master (
    output push, switch, frame_tick,
    input  x_pos, y_pos, move_pulse, btn_db
  );

  modport slave (
    input  push, switch, frame_tick,
    output x_pos, y_pos, move_pulse, btn_db
  );
endinterface

// File: rtl/square_move_scheduler.sv
// Square motion controller: debounces four buttons, resolves a direction and
// steps the square's top-left corner on frame boundaries, clamped to screen.

// One button lane: 2-FF synchroniser followed by a stable-count debouncer.
module smv_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // Synchronise the raw button into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], raw};
  end

  // Accept a new level only after it has differed for DEB_CYCLES samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      level <= 1'b0;
    end else if (sync_q[1] != level) begin
      if (cnt_q == CNT_LAST) begin
        level <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end
endmodule

module square_move_scheduler #(
  parameter int DEB_CYCLES  = 1000000,
  parameter int SIZE        = 40,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 220,
  parameter int SLOW_FRAMES = 4,
  parameter int FAST_FRAMES = 1,
  parameter int STEP        = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  square_move_scheduler_if.slave  bus
);
  localparam int NUM_LANES = 4;
  localparam logic signed [11:0] STEP_S = 12'(STEP);
  localparam logic signed [11:0] X_MAX  = 12'(H_RES - SIZE);
  localparam logic signed [11:0] Y_MAX  = 12'(V_RES - SIZE);

  typedef enum logic [1:0] {IDLE, ARMED, MOVE, REPEAT} state_t;

  state_t                 state, state_n;
  logic [7:0]             frame_cnt, frame_cnt_n;
  logic [7:0]             period_m1;
  logic [NUM_LANES-1:0]   push_raw, btn_db;
  logic                   up, right, left, down, dir_active, do_move;
  logic signed [11:0]     nx, ny;
  logic [9:0]             nx_c, ny_c, x_q, y_q;
  logic                   pulse_q;

  assign push_raw = bus.push;

  smv_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb [NUM_LANES-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (push_raw),
    .level (btn_db)
  );

  assign up    = btn_db[0];
  assign right = btn_db[1];
  assign left  = btn_db[2];
  assign down  = btn_db[3];
  // Opposite buttons cancel, so only an XOR of a pair yields motion.
  assign dir_active = (right ^ left) | (up ^ down);

  // Speed select is read live so a mid-repeat switch change takes effect at once.
  assign period_m1 = (bus.switch ? 8'(FAST_FRAMES) : 8'(SLOW_FRAMES)) - 8'd1;

  // Candidate position one step away, clamped to the visible area per axis.
  always_comb begin
    nx = $signed({2'b00, x_q});
    ny = $signed({2'b00, y_q});
    if (right & ~left) nx = nx + STEP_S;
    if (left & ~right) nx = nx - STEP_S;
    if (down & ~up)    ny = ny + STEP_S;
    if (up & ~down)    ny = ny - STEP_S;
    if (nx < 12'sd0)   nx = 12'sd0;
    if (nx > X_MAX)    nx = X_MAX;
    if (ny < 12'sd0)   ny = 12'sd0;
    if (ny > Y_MAX)    ny = Y_MAX;
    nx_c = nx[9:0];
    ny_c = ny[9:0];
  end

  // Scheduler next-state: frame ticks only count in ARMED and REPEAT.
  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    do_move     = 1'b0;
    case (state)
      IDLE: begin
        frame_cnt_n = '0;
        if (dir_active) state_n = ARMED;
      end
      ARMED: begin
        if (!dir_active)         state_n = IDLE;
        else if (bus.frame_tick) state_n = MOVE;
      end
      MOVE: begin
        do_move     = 1'b1;
        frame_cnt_n = '0;
        state_n     = dir_active ? REPEAT : IDLE;
      end
      REPEAT: begin
        if (!dir_active) begin
          state_n = IDLE;
        end else if (bus.frame_tick) begin
          if (frame_cnt >= period_m1) state_n = MOVE;
          else                        frame_cnt_n = frame_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Scheduler state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      frame_cnt <= frame_cnt_n;
    end
  end

  // Position registers load at the end of MOVE; the pulse marks a real change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= 10'(X_INIT);
      y_q     <= 10'(Y_INIT);
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= do_move && ((nx_c != x_q) || (ny_c != y_q));
      if (do_move) begin
        x_q <= nx_c;
        y_q <= ny_c;
      end
    end
  end

  assign bus.x_pos      = x_q;
  assign bus.y_pos      = y_q;
  assign bus.move_pulse = pulse_q;
  assign bus.btn_db     = btn_db;
endmodule
